// File: rtl/qracc_pkg.sv
// qracc_pkg
// Shared definitions for the bit-serial QR accelerator input path.
//   seq_state_t       : sequencer state encoding
//   SAT_GUARD_BITS    : extra headroom bits used when computing 2*acc + adc
//                       before saturating back to the accumulator width
//   plane_idx_bits()  : width of a bit-plane index for a given activation width
package qracc_pkg;

  typedef enum logic [2:0] {
    WARM  = 3'd0,
    IDLE  = 3'd1,
    DRIVE = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } seq_state_t;

  // 2*acc needs one extra bit and adding a narrower signed ADC value needs
  // one more, so two guard bits keep the intermediate sum exact.
  localparam int SAT_GUARD_BITS = 2;

  function automatic int plane_idx_bits(input int max_bits);
    return (max_bits > 1) ? $clog2(max_bits) : 1;
  endfunction

endpackage

// File: rtl/qracc_plane_slicer.sv
// qracc_plane_slicer
// Combinational bipolar bit-plane slicer. For plane k of a B-bit two's
// complement activation, the sign plane (k = B-1) drives the negative rail
// and every lower plane drives the positive rail.
//   x_vec    in  numRows*maxInBits  registered activations, row r at [r*maxInBits +: maxInBits]
//   plane_k  in  plane index being driven
//   n_bits   in  effective activation width B (1..maxInBits)
//   enable   in  gate; both rails are 0 when low
//   data_p   out positive plane drive, one bit per row
//   data_n   out negative plane drive, one bit per row
module qracc_plane_slicer
  import qracc_pkg::*;
#(
  parameter int numRows   = 128,
  parameter int maxInBits = 8,
  parameter int KW        = plane_idx_bits(maxInBits),
  parameter int BW        = KW + 1
) (
  input  logic [numRows*maxInBits-1:0] x_vec,
  input  logic [KW-1:0]                plane_k,
  input  logic [BW-1:0]                n_bits,
  input  logic                         enable,
  output logic [numRows-1:0]           data_p,
  output logic [numRows-1:0]           data_n
);

  logic                 sign_plane;
  logic [maxInBits-1:0] row_bits;

  // The top bit of a B-bit value carries weight -2^(B-1), so it goes to the
  // negative rail; all other bits carry positive weight.
  always_comb begin
    data_p     = '0;
    data_n     = '0;
    row_bits   = '0;
    sign_plane = ({1'b0, plane_k} == (n_bits - 1'b1));
    for (int r = 0; r < numRows; r++) begin
      row_bits  = x_vec[r*maxInBits +: maxInBits];
      data_p[r] = enable & ~sign_plane & row_bits[plane_k];
      data_n[r] = enable &  sign_plane & row_bits[plane_k];
    end
  end

endmodule

// File: rtl/qracc_bitserial_seq.sv
// qracc_bitserial_seq
// Bit-serial input sequencer and shift-accumulator in front of qr_acc_wrapper.
// Accepts one vector of signed activations, drives it MSB-first as bipolar
// bit-planes, and folds the per-column ADC results into signed partial sums
// with acc = sat(2*acc + adc).
//   clk, rst          clock and synchronous active-high reset
//   n_input_bits_cfg  activation width B, sampled on accept (0 -> 1, >max -> max)
//   x_valid_i/x_ready_o/x_data_i      activation vector handshake
//   mac_en_o          MAC enable to the wrapper, high whenever out of reset
//   data_p_o/data_n_o positive / negative plane drive
//   adc_out_i         signed per-column ADC results
//   psum_valid_o/psum_ready_i/psum_o  partial-sum handshake
//   busy_o            high in every state except IDLE
module qracc_bitserial_seq
  import qracc_pkg::*;
#(
  parameter int numRows      = 128,
  parameter int numCols      = 8,
  parameter int numAdcBits   = 4,
  parameter int maxInBits    = 8,
  parameter int accBits      = 16,
  parameter int numCfgBits   = 8,
  parameter int adcLatency   = 1,
  parameter int settleCycles = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [numCfgBits-1:0]         n_input_bits_cfg,
  input  logic                          x_valid_i,
  output logic                          x_ready_o,
  input  logic [numRows*maxInBits-1:0]  x_data_i,
  output logic                          mac_en_o,
  output logic [numRows-1:0]            data_p_o,
  output logic [numRows-1:0]            data_n_o,
  input  logic [numCols*numAdcBits-1:0] adc_out_i,
  output logic                          psum_valid_o,
  input  logic                          psum_ready_i,
  output logic [numCols*accBits-1:0]    psum_o,
  output logic                          busy_o
);

  localparam int KW = plane_idx_bits(maxInBits);
  localparam int BW = KW + 1;
  localparam int SW = accBits + SAT_GUARD_BITS;
  localparam int WW = (settleCycles > 1) ? $clog2(settleCycles) : 1;

  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SAT_GUARD_BITS+1){1'b0}}, {(accBits-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SAT_GUARD_BITS+1){1'b1}}, {(accBits-1){1'b0}}};
  localparam logic [adcLatency-1:0] TOP_TAG = adcLatency'(1) << (adcLatency - 1);

  seq_state_t                     state;
  logic [WW-1:0]                  warm_cnt;
  logic [numRows*maxInBits-1:0]   x_reg;
  logic [BW-1:0]                  b_reg;
  logic [BW-1:0]                  b_eff;
  logic [KW-1:0]                  plane_k;
  logic [adcLatency-1:0]          tag_sr;
  logic                           drive_now;
  logic                           capture;
  logic signed [accBits-1:0]      acc      [numCols];
  logic signed [accBits-1:0]      acc_next [numCols];
  logic signed [SW-1:0]           sum      [numCols];
  logic [numAdcBits-1:0]          adc_col  [numCols];

  assign drive_now    = (state == DRIVE);
  assign capture      = tag_sr[adcLatency-1];
  assign x_ready_o    = (state == IDLE);
  assign psum_valid_o = (state == OUT);
  assign busy_o       = (state != IDLE);
  assign mac_en_o     = 1'b1;

  // Zero is treated as one bit and anything wider than the datapath is clamped.
  always_comb begin
    b_eff = n_input_bits_cfg[BW-1:0];
    if (n_input_bits_cfg == '0)
      b_eff = BW'(1);
    else if (n_input_bits_cfg > numCfgBits'(maxInBits))
      b_eff = BW'(maxInBits);
  end

  // Sequencer: warm-up, accept, MSB-first plane walk, wait for the ADC pipe
  // to empty, then hold the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WARM;
      warm_cnt <= '0;
      x_reg    <= '0;
      b_reg    <= BW'(1);
      plane_k  <= '0;
    end else begin
      case (state)
        WARM: begin
          if (warm_cnt == WW'(settleCycles - 1))
            state <= IDLE;
          else
            warm_cnt <= warm_cnt + 1'b1;
        end
        IDLE: begin
          if (x_valid_i) begin
            x_reg   <= x_data_i;
            b_reg   <= b_eff;
            plane_k <= KW'(b_eff - 1'b1);
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (plane_k == '0)
            state <= DRAIN;
          else
            plane_k <= plane_k - 1'b1;
        end
        DRAIN: begin
          // Only the oldest tag left means this cycle lands the final capture.
          if (tag_sr == TOP_TAG)
            state <= OUT;
        end
        OUT: begin
          if (psum_ready_i)
            state <= IDLE;
        end
        default: state <= WARM;
      endcase
    end
  end

  // Each drive cycle enters a tag that emerges adcLatency cycles later,
  // marking the cycle whose ADC value belongs to that plane.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_sr <= '0;
    end else begin
      tag_sr[0] <= drive_now;
      for (int i = 1; i < adcLatency; i++)
        tag_sr[i] <= tag_sr[i-1];
    end
  end

  // Shift-accumulate in a widened domain, then clamp. Because the clamped
  // value is what gets stored, saturation stays sticky for the transaction.
  always_comb begin
    for (int c = 0; c < numCols; c++) begin
      adc_col[c] = adc_out_i[c*numAdcBits +: numAdcBits];
      sum[c] = {{(SAT_GUARD_BITS-1){acc[c][accBits-1]}}, acc[c], 1'b0}
             + {{(SW-numAdcBits){adc_col[c][numAdcBits-1]}}, adc_col[c]};
      if (sum[c] > SAT_MAX)
        acc_next[c] = SAT_MAX[accBits-1:0];
      else if (sum[c] < SAT_MIN)
        acc_next[c] = SAT_MIN[accBits-1:0];
      else
        acc_next[c] = sum[c][accBits-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < numCols; c++) acc[c] <= '0;
    end else if (x_ready_o && x_valid_i) begin
      for (int c = 0; c < numCols; c++) acc[c] <= '0;
    end else if (capture) begin
      for (int c = 0; c < numCols; c++) acc[c] <= acc_next[c];
    end
  end

  always_comb begin
    psum_o = '0;
    for (int c = 0; c < numCols; c++)
      psum_o[c*accBits +: accBits] = acc[c];
  end

  qracc_plane_slicer #(
    .numRows   (numRows),
    .maxInBits (maxInBits)
  ) u_slicer (
    .x_vec   (x_reg),
    .plane_k (plane_k),
    .n_bits  (b_reg),
    .enable  (drive_now),
    .data_p  (data_p_o),
    .data_n  (data_n_o)
  );

endmodule

// File: tb/tb_qracc_bitserial_seq.sv
// tb_qracc_bitserial_seq
// Directed bench for qracc_bitserial_seq. Two instances share all stimulus:
// dut_a uses the default 16-bit accumulator, dut_b a 6-bit accumulator so
// saturation is reachable with a 4-bit ADC.
module tb_qracc_bitserial_seq;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    n_input_bits_cfg;
  logic          x_valid;
  logic [1023:0] x_data;
  logic [31:0]   adc;
  logic          psum_ready;

  logic          x_ready_a, mac_en_a, psum_valid_a, busy_a;
  logic [127:0]  data_p_a, data_n_a, psum_a;
  logic          x_ready_b, mac_en_b, psum_valid_b, busy_b;
  logic [127:0]  data_p_b, data_n_b;
  logic [47:0]   psum_b;

  int assert_count = 0;
  int fail_count   = 0;

  logic [127:0]  plane_p [8];
  logic [127:0]  plane_n [8];
  logic [3:0]    adc_seq [8];

  always #5 clk = ~clk;

  qracc_bitserial_seq dut_a (
    .clk(clk), .rst(rst), .n_input_bits_cfg(n_input_bits_cfg),
    .x_valid_i(x_valid), .x_ready_o(x_ready_a), .x_data_i(x_data),
    .mac_en_o(mac_en_a), .data_p_o(data_p_a), .data_n_o(data_n_a),
    .adc_out_i(adc), .psum_valid_o(psum_valid_a), .psum_ready_i(psum_ready),
    .psum_o(psum_a), .busy_o(busy_a)
  );

  qracc_bitserial_seq #(.accBits(6)) dut_b (
    .clk(clk), .rst(rst), .n_input_bits_cfg(n_input_bits_cfg),
    .x_valid_i(x_valid), .x_ready_o(x_ready_b), .x_data_i(x_data),
    .mac_en_o(mac_en_b), .data_p_o(data_p_b), .data_n_o(data_n_b),
    .adc_out_i(adc), .psum_valid_o(psum_valid_b), .psum_ready_i(psum_ready),
    .psum_o(psum_b), .busy_o(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction with adcLatency=1: plane j is driven in cycle ta+1+j and
  // its ADC value is presented in cycle ta+2+j; psum is valid in ta+2+B.
  task automatic applyStimulus(input logic [7:0] cfg, input logic [1023:0] xv,
                               input int n_planes, input logic [127:0] exp_a,
                               input logic [47:0] exp_b, input int hold,
                               input string tag);
    int guard = 0;
    psum_ready = (hold == 0);
    while (!x_ready_a && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput({tag, "_ready"}, {127'd0, x_ready_a}, 128'd1);
    n_input_bits_cfg = cfg;
    x_data  = xv;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    x_data  = '0;
    n_input_bits_cfg = 8'd3;
    for (int j = 0; j < n_planes; j++) begin
      checkOutput($sformatf("%s_p%0d", tag, j), data_p_a, plane_p[j]);
      checkOutput($sformatf("%s_n%0d", tag, j), data_n_a, plane_n[j]);
      tick();
      adc = {8{adc_seq[j]}};
    end
    checkOutput({tag, "_valid_early"}, {127'd0, psum_valid_a}, 128'd0);
    tick();
    adc = '0;
    checkOutput({tag, "_valid"}, {126'd0, psum_valid_a, psum_valid_b}, 128'd3);
    checkOutput({tag, "_psum_a"}, psum_a, exp_a);
    checkOutput({tag, "_psum_b"}, {80'd0, psum_b}, {80'd0, exp_b});
    if (hold > 0) begin
      x_valid = 1'b1;
      x_data  = '1;
      for (int h = 0; h < hold; h++) begin
        checkOutput($sformatf("%s_hold_psum%0d", tag, h), psum_a, exp_a);
        checkOutput($sformatf("%s_hold_rdy%0d", tag, h), {126'd0, x_ready_a, psum_valid_a}, 128'd1);
        tick();
      end
      psum_ready = 1'b1;
      checkOutput({tag, "_hs_rdy"}, {126'd0, x_ready_a, psum_valid_a}, 128'd1);
      tick();
      checkOutput({tag, "_after_hs"}, {126'd0, x_ready_a, psum_valid_a}, 128'd2);
      x_valid = 1'b0;
      x_data  = '0;
    end else begin
      tick();
      checkOutput({tag, "_idle"}, {125'd0, x_ready_a, psum_valid_a, busy_a}, 128'd4);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1023:0] xv;
    bit            seen;

    rst = 1'b1;
    n_input_bits_cfg = 8'd4;
    x_valid    = 1'b0;
    x_data     = '0;
    adc        = '0;
    psum_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    checkOutput("rst_mac_en", {127'd0, mac_en_a}, 128'd1);
    checkOutput("rst_rdy_valid", {126'd0, x_ready_a, psum_valid_a}, 128'd0);
    checkOutput("rst_data", data_p_a | data_n_a, 128'd0);
    checkOutput("rst_psum", psum_a, 128'd0);

    // Warm-up: exactly five cycles of not-ready with MAC enabled
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("warm_rdy%0d", i), {126'd0, x_ready_a, mac_en_a}, 128'd1);
      checkOutput($sformatf("warm_data%0d", i), data_p_a | data_n_a, 128'd0);
      tick();
    end
    checkOutput("warm_done", {126'd0, x_ready_a, psum_valid_a}, 128'd2);

    // B=4, even rows 1010 (-6), odd rows 0101 (+5); ADC -1,3,0,2 -> 6
    for (int r = 0; r < 128; r++) xv[r*8 +: 8] = r[0] ? 8'h05 : 8'h0A;
    plane_p[0] = '0;             plane_n[0] = {32{4'h5}};
    plane_p[1] = {32{4'hA}};     plane_n[1] = '0;
    plane_p[2] = {32{4'h5}};     plane_n[2] = '0;
    plane_p[3] = {32{4'hA}};     plane_n[3] = '0;
    adc_seq[0] = 4'hF; adc_seq[1] = 4'h3; adc_seq[2] = 4'h0; adc_seq[3] = 4'h2;
    applyStimulus(8'd4, xv, 4, {8{16'd6}}, {8{6'd6}}, 0, "b4");

    // B=2, row0 = -1, row1 = +1; ADC 1,1 -> 3
    xv = '0; xv[7:0] = 8'hFF; xv[15:8] = 8'h01;
    plane_p[0] = '0;      plane_n[0] = 128'h1;
    plane_p[1] = 128'h3;  plane_n[1] = '0;
    adc_seq[0] = 4'h1; adc_seq[1] = 4'h1;
    applyStimulus(8'd2, xv, 2, {8{16'd3}}, {8{6'd3}}, 0, "b2");

    // Saturation: constant +7 -> 105 raw, 31 in 6 bits
    xv = '0;
    for (int j = 0; j < 4; j++) begin
      plane_p[j] = '0; plane_n[j] = '0; adc_seq[j] = 4'h7;
    end
    applyStimulus(8'd4, xv, 4, {8{16'd105}}, {8{6'd31}}, 0, "satpos");

    // Constant -8 -> -120 raw, -32 in 6 bits; consumer stalls 5 cycles
    for (int j = 0; j < 4; j++) adc_seq[j] = 4'h8;
    applyStimulus(8'd4, xv, 4, {8{16'hFF88}}, {8{6'h20}}, 5, "satneg");

    // B config 0 -> single sign plane
    xv = '1;
    plane_p[0] = '0; plane_n[0] = '1; adc_seq[0] = 4'h5;
    applyStimulus(8'd0, xv, 1, {8{16'd5}}, {8{6'd5}}, 0, "b0");

    // Oversized config clamps to 8; row0 = 0x80 distinguishes B=8 from B=4
    xv = '1; xv[7:0] = 8'h80;
    n_input_bits_cfg = 8'd20;
    x_data  = xv;
    x_valid = 1'b1;
    adc     = {8{4'h1}};
    checkOutput("abort_ready", {127'd0, x_ready_a}, 128'd1);
    tick();
    x_valid = 1'b0;
    checkOutput("clamp_sign_n", data_n_a, {128{1'b1}});
    checkOutput("clamp_sign_p", data_p_a, 128'd0);
    tick();
    checkOutput("clamp_p6", data_p_a, {{127{1'b1}}, 1'b0});
    tick();
    checkOutput("abort_pre_acc", psum_a, {8{16'd1}});

    // Reset mid-DRIVE aborts the transaction
    rst = 1'b1;
    tick();
    rst = 1'b0;
    adc = '0;
    checkOutput("abort_state", {125'd0, busy_a, x_ready_a, psum_valid_a}, 128'd4);
    checkOutput("abort_data", data_p_a | data_n_a, 128'd0);
    checkOutput("abort_psum", psum_a, 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (psum_valid_a || psum_valid_b) seen = 1'b1;
    end
    checkOutput("abort_no_psum", {127'd0, seen}, 128'd0);
    checkOutput("abort_recover", {126'd0, x_ready_a, mac_en_a}, 128'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
